// File: rtl/div32_seq_if.sv
// rtl/div32_seq_if.sv - request/result bundle between the execute stage and the sequential divider
interface div32_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder
    );
endinterface

// File: rtl/div32_seq.sv
// rtl/div32_seq.sv - restoring shift-subtract unsigned divider, one quotient bit per cycle
module div32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    div32_seq_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] divisor_l;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // One restoring step: bring down the next dividend bit, keep the difference if it did not borrow.
    always_comb begin
        trial  = {r_w, q_w[WIDTH-1]};
        diff   = trial - {1'b0, divisor_l};
        r_next = trial[WIDTH-1:0];
        q_next = {q_w[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            r_next = diff[WIDTH-1:0];
            q_next = {q_w[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            q_w         <= '0;
            r_w         <= '0;
            divisor_l   <= '0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Divide-by-zero short-circuits straight to the result.
                            state       <= DONE;
                            done_r      <= 1'b1;
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend;
                        end else begin
                            state     <= CALC;
                            q_w       <= bus.dividend;
                            r_w       <= '0;
                            divisor_l <= bus.divisor;
                            cnt       <= CNT_W'(WIDTH - 1);
                        end
                    end
                end
                CALC: begin
                    q_w <= q_next;
                    r_w <= r_next;
                    if (cnt == '0) begin
                        state       <= DONE;
                        done_r      <= 1'b1;
                        quotient_r  <= q_next;
                        remainder_r <= r_next;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
endmodule

// File: tb/tb_div32_seq.sv
// tb/tb_div32_seq.sv - scoreboard bench for the sequential divider
module tb_div32_seq;
    localparam int WIDTH = 32;

    logic clk;
    logic rst_n;

    div32_seq_if #(.WIDTH(WIDTH)) bus ();

    div32_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
    } result_t;

    result_t exp_q[$];
    int      n_pass  = 0;
    int      n_total = 0;
    logic    prev_done = 1'b0;

    function automatic void check(input string name, input logic [WIDTH-1:0] act,
                                  input logic [WIDTH-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.done) begin
                result_t e;
                check("done_width", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("quotient", bus.quotient, e.q);
                    check("remainder", bus.remainder, e.r);
                end
            end
            prev_done <= bus.done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
    endtask

    // Issues one operation; lat = rising edges after the sampling edge until done is visible.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          output int lat);
        result_t e;
        wait_idle();
        e.q = eq;
        e.r = er;
        exp_q.push_back(e);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!bus.done) check("done_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] a, b;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 100 / 7 with busy and hold checks.
        bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
        exp_q.push_back('{q: 32'd14, r: 32'd2});
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", {31'd0, bus.busy}, 32'd1);
        check("quotient_hold_calc", bus.quotient, 32'd0);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("latency_100_7", lat, 32'd32);
        check("busy_in_done", {31'd0, bus.busy}, 32'd1);

        run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, lat);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, lat);

        run_op(32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, lat);
        check("latency_div0", lat, 32'd0);
        run_op(32'd0, 32'd13, 32'd0, 32'd0, lat);

        // 5 / 9, with a second start held high across the whole first operation.
        wait_idle();
        exp_q.push_back('{q: 32'd0, r: 32'd5});
        exp_q.push_back('{q: 32'd10, r: 32'd0});
        bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 32'd9;
        @(posedge clk);
        @(negedge clk);
        bus.dividend = 32'd50; bus.divisor = 32'd5;
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("latency_5_9", lat, 32'd32);
        @(negedge clk);
        check("idle_gap_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("second_accepted", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        check("first_result_held", bus.quotient, 32'd0);
        lat = 0;
        while (!bus.done && lat < 100) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check("latency_50_5", lat, 32'd32);

        // Reset mid-operation: no scoreboard entry, so any done would be flagged.
        wait_idle();
        bus.start = 1'b1; bus.dividend = 32'd1000; bus.divisor = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(32'd9, 32'd2, 32'd4, 32'd1, lat);

        for (int i = 0; i < 2000; i++) begin
            a = $urandom;
            case (i % 4)
                0:       b = 32'($urandom_range(0, 15));
                1:       b = $urandom >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if (b == 0) run_op(a, b, 32'hFFFF_FFFF, a, lat);
            else        run_op(a, b, a / b, a % b, lat);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
